npc_halt_ctrl: RTL and testbench

- Core-side initiator of the simulation halt protocol.
- Watches the commit stage for `ebreak` and captures the guest return code from a0 (x10, low 32 bits), the PC and the cycle count.
- Freezes the pipeline, waits for in-flight memory traffic to drain, then presents a valid/ready halt report to the simulation host, which consumes it and ends the run.
- Sits between the NPC writeback/commit stage and the top-level sim harness.

---
 rtl/npc_halt_pkg.sv | 13 +
 rtl/npc_halt_cyc_cnt.sv | 21 ++
 rtl/npc_halt_ctrl.sv | 137 +++++++++++++
 tb/tb_npc_halt_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/npc_halt_pkg.sv
// Shared types and constants for the NPC simulation-halt controller.
package npc_halt_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    REPORT = 2'd2,
    HALTED = 2'd3
  } halt_state_e;

  localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

endpackage

// File: rtl/npc_halt_cyc_cnt.sv
// Free-running 64-bit cycle counter; holds its value while freeze is high.
module npc_halt_cyc_cnt (
  input  logic        clock,
  input  logic        reset,
  input  logic        freeze,
  output logic [63:0] count
);

  logic [63:0] r_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= 64'd0;
    end else if (!freeze) begin
      r_count <= r_count + 64'd1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/npc_halt_ctrl.sv
// Core-side halt initiator: ebreak capture, pipeline freeze, drain, valid/ready report.
// Optional drain watchdog enabled by defining HALT_TIMEOUT_EN.
module npc_halt_ctrl
  import npc_halt_pkg::*;
#(
  parameter int          XLEN          = 64,
  parameter logic [31:0] EBREAK_ENC    = EBREAK_INST,
  parameter int          DRAIN_TIMEOUT = 255,
  parameter int          TO_CNT_W      = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            commit_valid,
  input  logic [31:0]     commit_inst,
  input  logic [XLEN-1:0] commit_pc,
  input  logic [XLEN-1:0] a0,
  input  logic            lsu_busy,
  output logic            stall,
  output logic            halt_valid,
  input  logic            halt_ready,
  output logic [31:0]     halt_code,
  output logic [XLEN-1:0] halt_pc,
  output logic [63:0]     halt_cycles,
  output logic            halt_timeout,
  output logic            halted
);

  halt_state_e     r_state;
  logic            r_stall;
  logic            r_halt_valid;
  logic            r_halted;
  logic [31:0]     r_code;
  logic [XLEN-1:0] r_pc;
  logic [63:0]     r_cycles;

  logic [63:0]     w_cyc_count;
  logic            w_ebreak;
  logic            w_handshake;

  // The guest return code is only the low word of a0.
  if (XLEN > 32) begin : g_a0_hi
    logic w_unused_a0_hi;
    assign w_unused_a0_hi = ^a0[XLEN-1:32];
  end

  // Elaboration marker for an out-of-range watchdog configuration.
  if (DRAIN_TIMEOUT < 1 || DRAIN_TIMEOUT >= (2 ** TO_CNT_W)) begin : g_bad_drain_timeout_cfg
  end

  assign w_ebreak    = commit_valid && (commit_inst == EBREAK_ENC);
  assign w_handshake = r_halt_valid && halt_ready;

  npc_halt_cyc_cnt u_cyc_cnt (
    .clock  (clock),
    .reset  (reset),
    .freeze (r_state != RUN),
    .count  (w_cyc_count)
  );

`ifdef HALT_TIMEOUT_EN
  logic [TO_CNT_W-1:0] r_to_cnt;
  logic                r_halt_timeout;
  logic                w_to_hit;

  assign w_to_hit     = (r_to_cnt + TO_CNT_W'(1)) == TO_CNT_W'(DRAIN_TIMEOUT);
  assign halt_timeout = r_halt_timeout;
`else
  assign halt_timeout = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= RUN;
      r_stall      <= 1'b0;
      r_halt_valid <= 1'b0;
      r_halted     <= 1'b0;
      r_code       <= 32'd0;
      r_pc         <= '0;
      r_cycles     <= 64'd0;
`ifdef HALT_TIMEOUT_EN
      r_to_cnt       <= '0;
      r_halt_timeout <= 1'b0;
`endif
    end else begin
      case (r_state)
        RUN: begin
          if (w_ebreak) begin
            r_code   <= a0[31:0];
            r_pc     <= commit_pc;
            r_cycles <= w_cyc_count;
            r_stall  <= 1'b1;
            r_state  <= DRAIN;
`ifdef HALT_TIMEOUT_EN
            r_to_cnt <= '0;
`endif
          end
        end
        DRAIN: begin
          if (!lsu_busy) begin
            r_halt_valid <= 1'b1;
            r_state      <= REPORT;
          end
`ifdef HALT_TIMEOUT_EN
          else if (w_to_hit) begin
            r_halt_valid   <= 1'b1;
            r_halt_timeout <= 1'b1;
            r_state        <= REPORT;
          end else begin
            r_to_cnt <= r_to_cnt + TO_CNT_W'(1);
          end
`endif
        end
        REPORT: begin
          if (w_handshake) begin
            r_halt_valid <= 1'b0;
            r_halted     <= 1'b1;
            r_state      <= HALTED;
          end
        end
        HALTED: begin
          r_state <= HALTED;
        end
        default: begin
          r_state <= RUN;
        end
      endcase
    end
  end

  assign stall       = r_stall;
  assign halt_valid  = r_halt_valid;
  assign halted      = r_halted;
  assign halt_code   = r_code;
  assign halt_pc     = r_pc;
  assign halt_cycles = r_cycles;

endmodule

// File: tb/tb_npc_halt_ctrl.sv
// Directed self-checking bench for npc_halt_ctrl (works with or without HALT_TIMEOUT_EN).
module tb_npc_halt_ctrl;

  localparam int          XLEN   = 64;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;
`ifdef HALT_TIMEOUT_EN
  localparam int BUSY_CYCLES = 3;
`else
  localparam int BUSY_CYCLES = 10;
`endif

  logic            clock;
  logic            reset;
  logic            commit_valid;
  logic [31:0]     commit_inst;
  logic [XLEN-1:0] commit_pc;
  logic [XLEN-1:0] a0;
  logic            lsu_busy;
  logic            stall;
  logic            halt_valid;
  logic            halt_ready;
  logic [31:0]     halt_code;
  logic [XLEN-1:0] halt_pc;
  logic [63:0]     halt_cycles;
  logic            halt_timeout;
  logic            halted;

  logic [63:0] tb_cyc;
  int          checks;
  int          errors;

  npc_halt_ctrl #(
    .XLEN          (XLEN),
    .EBREAK_ENC    (EBREAK),
    .DRAIN_TIMEOUT (4),
    .TO_CNT_W      (8)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .commit_valid (commit_valid),
    .commit_inst  (commit_inst),
    .commit_pc    (commit_pc),
    .a0           (a0),
    .lsu_busy     (lsu_busy),
    .stall        (stall),
    .halt_valid   (halt_valid),
    .halt_ready   (halt_ready),
    .halt_code    (halt_code),
    .halt_pc      (halt_pc),
    .halt_cycles  (halt_cycles),
    .halt_timeout (halt_timeout),
    .halted       (halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference cycle index: equals the number of rising edges since reset release.
  always @(posedge clock or negedge reset) begin
    if (!reset) tb_cyc <= 64'd0;
    else        tb_cyc <= tb_cyc + 64'd1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset        = 1'b0;
    commit_valid = 1'b0;
    commit_inst  = NOP;
    commit_pc    = '0;
    a0           = '0;
    lsu_busy     = 1'b0;
    halt_ready   = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  // Retires one ebreak in the current cycle; returns its cycle index; ends one cycle later.
  task automatic fire_ebreak(input logic [63:0] a, input logic [63:0] pc, output logic [63:0] n);
    commit_valid = 1'b1;
    commit_inst  = EBREAK;
    commit_pc    = pc;
    a0           = a;
    n            = tb_cyc;
    step();
    commit_valid = 1'b0;
    commit_inst  = NOP;
  endtask

  logic [63:0] n;

  initial begin
    checks = 0;
    errors = 0;

    // Basic ebreak
    do_reset();
    chk("rst_stall", {63'd0, stall}, 64'd0);
    chk("rst_valid", {63'd0, halt_valid}, 64'd0);
    chk("rst_halted", {63'd0, halted}, 64'd0);
    chk("rst_timeout", {63'd0, halt_timeout}, 64'd0);
    chk("rst_code", {32'd0, halt_code}, 64'd0);
    chk("rst_pc", halt_pc, 64'd0);
    chk("rst_cycles", halt_cycles, 64'd0);
    while (tb_cyc != 64'd100) step();
    halt_ready = 1'b1;
    fire_ebreak(64'hFFFF_0000_0000_0000, 64'h8000_0000, n);
    chk("basic_stall_n1", {63'd0, stall}, 64'd1);
    chk("basic_valid_n1", {63'd0, halt_valid}, 64'd0);
    step();
    chk("basic_valid_n2", {63'd0, halt_valid}, 64'd1);
    chk("basic_code", {32'd0, halt_code}, 64'd0);
    chk("basic_cycles", halt_cycles, 64'd100);
    chk("basic_pc", halt_pc, 64'h8000_0000);
    chk("basic_halted_n2", {63'd0, halted}, 64'd0);
    step();
    chk("basic_halted_n3", {63'd0, halted}, 64'd1);
    chk("basic_valid_n3", {63'd0, halt_valid}, 64'd0);
    chk("basic_stall_n3", {63'd0, stall}, 64'd1);
    $display("basic ebreak: code=%h cycles=%0d halted=%0b", halt_code, halt_cycles, halted);

    // Nonzero code, host back-pressure
    do_reset();
    repeat (7) step();
    halt_ready = 1'b0;
    fire_ebreak(64'h1234_5678_0000_0001, 64'h8000_0040, n);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", {63'd0, halt_valid}, 64'd1);
      chk("hold_code", {32'd0, halt_code}, 64'h1);
      chk("hold_pc", halt_pc, 64'h8000_0040);
      chk("hold_cycles", halt_cycles, n);
      chk("hold_halted", {63'd0, halted}, 64'd0);
      step();
    end
    halt_ready = 1'b1;
    step();
    chk("hold_halted_after", {63'd0, halted}, 64'd1);
    chk("hold_valid_after", {63'd0, halt_valid}, 64'd0);
    $display("nonzero code: code=%h pc=%h cycles=%0d", halt_code, halt_pc, halt_cycles);

    // Drain on lsu_busy
    do_reset();
    repeat (3) step();
    lsu_busy   = 1'b1;
    halt_ready = 1'b1;
    fire_ebreak(64'h0000_0000_0000_0002, 64'h8000_0100, n);
    repeat (BUSY_CYCLES) step();
    chk("drain_valid_busy", {63'd0, halt_valid}, 64'd0);
    lsu_busy = 1'b0;
    step();
    chk("drain_valid", {63'd0, halt_valid}, 64'd1);
    chk("drain_timeout", {63'd0, halt_timeout}, 64'd0);
    chk("drain_code", {32'd0, halt_code}, 64'd2);
    step();
    chk("drain_halted", {63'd0, halted}, 64'd1);
    $display("drain: busy_cycles=%0d timeout=%0b halted=%0b", BUSY_CYCLES, halt_timeout, halted);

    // LSU stuck busy
    do_reset();
    repeat (4) step();
    lsu_busy   = 1'b1;
    halt_ready = 1'b0;
    fire_ebreak(64'h0000_0000_0000_0007, 64'h8000_0200, n);
`ifdef HALT_TIMEOUT_EN
    repeat (3) step();
    chk("to_valid_early", {63'd0, halt_valid}, 64'd0);
    step();
    chk("to_valid", {63'd0, halt_valid}, 64'd1);
    chk("to_timeout", {63'd0, halt_timeout}, 64'd1);
    chk("to_code", {32'd0, halt_code}, 64'd7);
    halt_ready = 1'b1;
    step();
    chk("to_halted", {63'd0, halted}, 64'd1);
    chk("to_timeout_held", {63'd0, halt_timeout}, 64'd1);
`else
    repeat (300) step();
    chk("stuck_valid", {63'd0, halt_valid}, 64'd0);
    chk("stuck_timeout", {63'd0, halt_timeout}, 64'd0);
    chk("stuck_stall", {63'd0, stall}, 64'd1);
    lsu_busy = 1'b0;
    step();
    chk("stuck_valid_release", {63'd0, halt_valid}, 64'd1);
    chk("stuck_timeout_release", {63'd0, halt_timeout}, 64'd0);
    chk("stuck_cycles", halt_cycles, n);
`endif
    $display("lsu stuck: valid=%0b timeout=%0b code=%h", halt_valid, halt_timeout, halt_code);

    // Spurious triggers
    do_reset();
    repeat (5) step();
    commit_valid = 1'b0;
    commit_inst  = EBREAK;
    a0           = 64'h0000_0000_0000_00CC;
    repeat (3) step();
    chk("spur_novalid_stall", {63'd0, stall}, 64'd0);
    commit_valid = 1'b1;
    commit_inst  = NOP;
    step();
    chk("spur_nop_stall", {63'd0, stall}, 64'd0);
    chk("spur_nop_valid", {63'd0, halt_valid}, 64'd0);
    lsu_busy   = 1'b1;
    halt_ready = 1'b1;
    fire_ebreak(64'h0000_0000_0000_00AA, 64'h8000_1000, n);
    commit_valid = 1'b1;
    commit_inst  = EBREAK;
    commit_pc    = 64'h8000_2000;
    a0           = 64'h0000_0000_0000_00BB;
    step();
    chk("spur_early_ready_valid", {63'd0, halt_valid}, 64'd0);
    chk("spur_early_ready_halted", {63'd0, halted}, 64'd0);
    repeat (2) step();
    commit_valid = 1'b0;
    lsu_busy     = 1'b0;
    step();
    chk("spur_valid", {63'd0, halt_valid}, 64'd1);
    chk("spur_code", {32'd0, halt_code}, 64'hAA);
    chk("spur_pc", halt_pc, 64'h8000_1000);
    chk("spur_cycles", halt_cycles, n);
    chk("spur_halted_pre", {63'd0, halted}, 64'd0);
    step();
    chk("spur_halted", {63'd0, halted}, 64'd1);
    $display("spurious: code=%h pc=%h halted=%0b", halt_code, halt_pc, halted);

    // Asynchronous reset while in REPORT
    do_reset();
    repeat (2) step();
    fire_ebreak(64'h0000_0000_0000_0055, 64'h8000_3000, n);
    step();
    chk("arst_pre_valid", {63'd0, halt_valid}, 64'd1);
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_stall", {63'd0, stall}, 64'd0);
    chk("arst_valid", {63'd0, halt_valid}, 64'd0);
    chk("arst_code", {32'd0, halt_code}, 64'd0);
    chk("arst_pc", halt_pc, 64'd0);
    chk("arst_cycles", halt_cycles, 64'd0);
    chk("arst_halted", {63'd0, halted}, 64'd0);
    chk("arst_timeout", {63'd0, halt_timeout}, 64'd0);
    @(negedge clock);
    reset = 1'b1;
    step();
    chk("arst_run_stall", {63'd0, stall}, 64'd0);
    halt_ready = 1'b1;
    fire_ebreak(64'h0000_0000_0000_0066, 64'h8000_4000, n);
    chk("arst_new_stall", {63'd0, stall}, 64'd1);
    step();
    chk("arst_new_valid", {63'd0, halt_valid}, 64'd1);
    chk("arst_new_code", {32'd0, halt_code}, 64'h66);
    chk("arst_new_cycles", halt_cycles, n);
    step();
    chk("arst_new_halted", {63'd0, halted}, 64'd1);
    $display("async reset: code=%h cycles=%0d halted=%0b", halt_code, halt_cycles, halted);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
